// File: rtl/ks_wide_add_sequencer.sv
// ks_wide_add_sequencer
// Byte-serial multi-precision add controller around an external 8-bit adder core.
// Operand byte pairs arrive LSB first on a valid/ready stream. Each pair passes
// combinationally to the core. The core's sum byte is registered into a
// single-entry output stage, and its carry-out is chained into the next byte.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ena                enable; low freezes all state and blocks both handshakes
//   start, cin         begin an operation (acted on in IDLE) with initial carry
//   in_valid/in_ready  operand stream handshake; in_a, in_b operand bytes
//   add_a/b/cin        drive the adder core; add_sum/add_cout come back from it
//   out_valid/ready    sum stream handshake; out_sum byte, out_last marks MSB
//   carry_out/overflow final carry and signed overflow of the last completed op
//   busy, done         operation in progress / one-cycle completion pulse
module ks_wide_add_sequencer #(
    parameter int unsigned NBYTES = 4,
    parameter bit          CIN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       cin,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_last,
    output logic       carry_out,
    output logic       overflow,
    output logic       busy,
    output logic       done
);

    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_out_valid;
    logic [7:0]      r_out_sum;
    logic            r_out_last;
    logic            r_carry_out;
    logic            r_overflow;
    logic            r_done;

    logic            w_in_ready;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_last_byte;

    // Accept a new pair only while running, when the output slot is free or being drained this cycle
    assign w_in_ready  = ena & (r_state == S_RUN) & (~r_out_valid | out_ready);
    assign w_in_xfer   = in_valid & w_in_ready;
    assign w_out_xfer  = ena & r_out_valid & out_ready;
    assign w_last_byte = (r_idx == IW'(NBYTES - 1));

    // Adder core is a pure pass-through; its delay lands in the in_a -> out_sum path
    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_cin = r_carry;

    // Sequencer state, carry chain and output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= 8'h00;
            r_out_last  <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_carry     <= cin & CIN_EN;
                        r_idx       <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_in_xfer) begin
                        // Simultaneous output transfer is implied: the slot is simply overwritten
                        r_out_sum   <= add_sum;
                        r_carry     <= add_cout;
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_last_byte;
                        r_idx       <= r_idx + IW'(1);
                        if (w_last_byte) begin
                            r_carry_out <= add_cout;
                            r_overflow  <= (in_a[7] == in_b[7]) & (add_sum[7] != in_a[7]);
                            r_state     <= S_DRAIN;
                        end
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Slot holds the MSB byte; completion is its departure
                    if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: doc/ks_wide_add_sequencer.md
Name: ks_wide_add_sequencer

Overview:
Byte-serial multi-precision add controller wrapped around the 8-bit Kogge-Stone adder core. It accepts operand byte pairs least-significant byte first and drives the core's a/b/carry-in. It registers each sum byte and chains the carry between bytes, which turns the 8-bit core into an NBYTES-wide adder. Upstream it takes a valid/ready operand stream; downstream it emits a valid/ready sum-byte stream plus final carry and overflow flags.

Parameters:
NBYTES, 4, operand width in bytes (legal 2..16); byte counter width = clog2(NBYTES)
CIN_EN, 1, 1 = honour cin at start; 0 = initial carry forced to 0

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  design enable; low freezes all state
start  input  1  begin new operation (level sampled; acted on only in IDLE)
cin  input  1  initial carry, sampled with accepted start
in_valid  input  1  operand byte pair valid
in_ready  output  1  sequencer can accept operand pair
in_a  input  8  operand A byte
in_b  input  8  operand B byte
add_a  output  8  to adder core a (combinational = in_a)
add_b  output  8  to adder core b (combinational = in_b)
add_cin  output  1  to adder core carry-in (= carry register)
add_sum  input  8  from adder core sum
add_cout  input  1  from adder core carry-out
out_valid  output  1  sum byte valid
out_ready  input  1  downstream accepts sum byte
out_sum  output  8  registered sum byte
out_last  output  1  qualifies out_sum as MSB byte
carry_out  output  1  final carry of last completed op
overflow  output  1  signed overflow of last completed op
busy  output  1  operation in progress
done  output  1  one-cycle pulse at completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; carry reg 0; byte index 0. Reset mid-operation aborts it: out_valid drops immediately, no done pulse, partial flags discarded.
- ena=0: no register updates; in_ready=0; out_valid/out_sum held; no handshake completes on either side.
- FSM: IDLE, RUN, DRAIN.
- IDLE: busy=0. If start=1 and ena=1: carry reg <= cin & CIN_EN, idx <= 0, carry_out <= 0, overflow <= 0, state -> RUN.
- RUN: busy=1; in_ready = ena & (~out_valid | out_ready). Input transfer = in_valid & in_ready. On transfer: out_sum <= add_sum, carry reg <= add_cout, out_valid <= 1, out_last <= (idx==NBYTES-1), idx++. If the last byte transfers: carry_out <= add_cout, overflow <= (in_a[7]==in_b[7]) & (add_sum[7]!=in_a[7]), state -> DRAIN.
- Output stage is a single register. An output transfer (out_valid & out_ready & ena) with no simultaneous input transfer clears out_valid. With a simultaneous input transfer, out_valid stays 1 and data is replaced, giving one byte per cycle throughput.
- DRAIN: in_ready=0. When the last byte transfers out: out_valid <= 0, out_last <= 0, done <= 1 for exactly one cycle, state -> IDLE.
- busy is 1 in RUN and DRAIN and falls in the same cycle done rises.
- start outside IDLE is ignored.
- carry_out/overflow hold until the next accepted start.
- Latency: operand pair accepted at cycle t appears on out_sum at t+1. Minimum op length is NBYTES+1 cycles from the first input transfer to done.
- Adder interface is purely combinational pass-through; the core's propagation delay sits in this block's input-to-register path.
- Byte index wraps to 0 only via a new start; there is no wrap inside an operation.

Test Plan:
- NBYTES=4, cin=0, A=0x01234567, B=0x89ABCDEF, out_ready=1 -> out_sum bytes 56,13,CF,8A; out_last on 4th; carry_out=0; overflow=0; done one pulse.
- A=0xFFFFFFFF, B=0x00000001 -> bytes 00,00,00,00; carry_out=1; overflow=0.
- A=0x7FFFFFFF, B=0x00000001 -> bytes 00,00,00,80; carry_out=0; overflow=1. Repeat with A=0, B=0, cin=1 -> 01,00,00,00; with CIN_EN=0 -> 00,00,00,00.
- Backpressure: out_ready=0 for 3 cycles after byte 1 -> in_ready=0; out_sum stable at 56; no input consumed. Release -> sequence completes unchanged.
- Assert start while busy mid-op -> ignored, result unchanged. Drop ena for 2 cycles mid-op -> all outputs frozen, result unchanged.
- rst_n=0 after 2 bytes -> out_valid=0, busy=0, done never pulses. Next op 0x01234567+0x89ABCDEF -> correct result.
